// File: rtl/sm_trace_buffer_if.sv
// Trace-buffer bus: CPU-side sample, breakpoint and readout signals plus status.
// Readout width follows SM_TRACE_WATCH_EN (adds the watched register per entry).
interface sm_trace_buffer_if #(parameter int DEPTH_LOG2 = 4);
`ifdef SM_TRACE_WATCH_EN
  localparam int RD_W = 96;
`else
  localparam int RD_W = 64;
`endif
  logic                  arm;
  logic                  valid;
  logic [31:0]           pc;
  logic [31:0]           instr;
  logic [31:0]           watch;
  logic                  bpEn;
  logic [31:0]           bpAddr;
  logic [DEPTH_LOG2-1:0] rdIdx;
  logic [RD_W-1:0]       rdData;
  logic                  busy;
  logic                  done;
  logic                  hit;
  logic                  timeout;
  logic [DEPTH_LOG2:0]   count;
  logic [15:0]           cycles;

  modport master (output arm, valid, pc, instr, watch, bpEn, bpAddr, rdIdx,
                  input  rdData, busy, done, hit, timeout, count, cycles);
  modport slave  (input  arm, valid, pc, instr, watch, bpEn, bpAddr, rdIdx,
                  output rdData, busy, done, hit, timeout, count, cycles);
endinterface

// File: rtl/sm_trace_buffer.sv
// Circular PC/instr trace with breakpoint post-capture, watchdog and registered readout.
// Optional macro SM_TRACE_WATCH_EN widens entries with the watched register value.
module sm_trace_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int POST       = 4,
  parameter int NCYCLE     = 120
)(
  input logic              clk,
  input logic              rst_n,
  sm_trace_buffer_if.slave trc
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef SM_TRACE_WATCH_EN
  localparam int EW = 96;
`else
  localparam int EW = 64;
`endif
  localparam logic [DEPTH_LOG2-1:0] POST_L = DEPTH_LOG2'(POST);
  localparam logic [15:0]           NC_L   = 16'(NCYCLE);
  localparam logic [DEPTH_LOG2:0]   FULL_L = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_POST, S_DONE} state_t;

  logic [EW-1:0]         mem [DEPTH];
  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, post_q, post_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [15:0]           cycles_q, cycles_d;
  logic                  hit_q, hit_d, to_q, to_d;
  logic [EW-1:0]         rd_q, rd_d, entry;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic                  busy, capture, bp_match, wd_exp, post_last;

`ifdef SM_TRACE_WATCH_EN
  assign entry = {trc.pc, trc.instr, trc.watch};
`else
  logic unused_watch;
  assign unused_watch = ^trc.watch;
  assign entry = {trc.pc, trc.instr};
`endif

  assign busy      = (state_q == S_RUN) || (state_q == S_POST);
  assign capture   = busy && trc.valid;
  assign bp_match  = (state_q == S_RUN) && trc.valid && trc.bpEn && (trc.pc == trc.bpAddr);
  assign wd_exp    = busy && ((cycles_q + 16'd1) == NC_L);
  assign post_last = (state_q == S_POST) && trc.valid && ((post_q + 1'b1) == POST_L);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (trc.arm) state_d = S_RUN;
    else begin
      unique case (state_q)
        S_RUN: begin
          if (wd_exp || (bp_match && POST == 0)) state_d = S_DONE;
          else if (bp_match)                     state_d = S_POST;
        end
        S_POST:  if (wd_exp || post_last) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs: all straight from registers
  always_comb begin
    trc.busy    = busy;
    trc.done    = (state_q == S_DONE);
    trc.hit     = hit_q;
    trc.timeout = to_q;
    trc.count   = count_q;
    trc.cycles  = cycles_q;
    trc.rdData  = rd_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    cycles_d = cycles_q;
    hit_d    = hit_q;
    to_d     = to_q;
    post_d   = post_q;
    if (trc.arm) begin
      wr_ptr_d = '0;
      count_d  = '0;
      cycles_d = '0;
      hit_d    = 1'b0;
      to_d     = 1'b0;
      post_d   = '0;
    end else if (busy) begin
      cycles_d = cycles_q + 16'd1;
      if (capture) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (count_q != FULL_L) count_d = count_q + 1'b1;
      end
      if (bp_match)                           hit_d  = 1'b1;
      if (state_q == S_POST && trc.valid)     post_d = post_q + 1'b1;
      if (wd_exp)                             to_d   = 1'b1;
    end
  end

  // Oldest entry sits count slots behind the write pointer; out-of-range reads give 0
  assign rd_addr = wr_ptr_q - count_q[DEPTH_LOG2-1:0] + trc.rdIdx;
  assign rd_d    = ({1'b0, trc.rdIdx} < count_q) ? mem[rd_addr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      cycles_q <= '0;
      hit_q    <= 1'b0;
      to_q     <= 1'b0;
      post_q   <= '0;
      rd_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      cycles_q <= cycles_d;
      hit_q    <= hit_d;
      to_q     <= to_d;
      post_q   <= post_d;
      rd_q     <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture && !trc.arm) mem[wr_ptr_q] <= entry;
  end
endmodule

// File: tb/tb_sm_trace_buffer.sv
// Directed bench for sm_trace_buffer: two instances (POST=4 and POST=0), NCYCLE=120.
module tb_sm_trace_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm_trace_buffer_if #(.DEPTH_LOG2(4)) ifa ();
  sm_trace_buffer_if #(.DEPTH_LOG2(4)) ifb ();

  sm_trace_buffer #(.DEPTH_LOG2(4), .POST(4), .NCYCLE(120)) u_dut  (.clk(clk), .rst_n(rst_n), .trc(ifa));
  sm_trace_buffer #(.DEPTH_LOG2(4), .POST(0), .NCYCLE(120)) u_dut0 (.clk(clk), .rst_n(rst_n), .trc(ifb));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [31:0] p);
    return p ^ 32'h2400_0000;
  endfunction

  function automatic logic [127:0] ent(input logic [31:0] p);
`ifdef SM_TRACE_WATCH_EN
    return {32'h0, p, ins(p), 32'hAA};
`else
    return {64'h0, p, ins(p)};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_a(input logic v, input logic [31:0] p);
    ifa.valid = v; ifa.pc = p; ifa.instr = ins(p);
    tick();
  endtask

  task automatic feed_b(input logic v, input logic [31:0] p);
    ifb.valid = v; ifb.pc = p; ifb.instr = ins(p);
    tick();
  endtask

  task automatic arm_a();
    ifa.arm = 1'b1; ifa.valid = 1'b0;
    tick();
    ifa.arm = 1'b0;
  endtask

  initial begin
    ifa.arm = 0; ifa.valid = 0; ifa.pc = 0; ifa.instr = 0; ifa.watch = 32'hAA;
    ifa.bpEn = 0; ifa.bpAddr = 0; ifa.rdIdx = 0;
    ifb.arm = 0; ifb.valid = 0; ifb.pc = 0; ifb.instr = 0; ifb.watch = 32'hAA;
    ifb.bpEn = 0; ifb.bpAddr = 0; ifb.rdIdx = 0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle: valid traffic without arm records nothing
    for (int p = 0; p < 10; p++) feed_a(1'b1, 32'(p));
    chk("idle_count", 128'(ifa.count), 128'd0);
    chk("idle_busy",  128'(ifa.busy),  128'd0);
    chk("idle_done",  128'(ifa.done),  128'd0);
    chk("idle_rd",    128'(ifa.rdData), 128'd0);

    // Wrap: 20 captures into 16 slots
    arm_a();
    chk("arm_busy",  128'(ifa.busy),  128'd1);
    chk("arm_count", 128'(ifa.count), 128'd0);
    for (int p = 0; p < 20; p++) feed_a(1'b1, 32'(p));
    chk("wrap_count",  128'(ifa.count),  128'd16);
    chk("wrap_cycles", 128'(ifa.cycles), 128'd20);
    ifa.valid = 0; ifa.rdIdx = 4'd0;
    tick();
    chk("wrap_rd0", 128'(ifa.rdData), ent(4));
    ifa.rdIdx = 4'd15;
    tick();
    chk("wrap_rd15", 128'(ifa.rdData), ent(19));

    // Breakpoint at pc 7 with 4 post captures
    arm_a();
    ifa.bpEn = 1; ifa.bpAddr = 32'd7;
    for (int p = 0; p < 16; p++) begin
      feed_a(1'b1, 32'(p));
      if (p == 10) chk("bp_done_early", 128'(ifa.done), 128'd0);
      if (p == 11) begin
        chk("bp_done", 128'(ifa.done),  128'd1);
        chk("bp_hit",  128'(ifa.hit),   128'd1);
        chk("bp_cnt",  128'(ifa.count), 128'd12);
      end
    end
    ifa.valid = 0;
    chk("bp_cnt_hold", 128'(ifa.count),   128'd12);
    chk("bp_to",       128'(ifa.timeout), 128'd0);
    ifa.rdIdx = 4'd11;
    tick();
    chk("bp_newest", 128'(ifa.rdData), ent(11));
    ifa.rdIdx = 4'd0;
    tick();
    chk("bp_oldest", 128'(ifa.rdData), ent(0));

    // POST=0 instance: done right after the matching capture
    ifb.arm = 1; tick(); ifb.arm = 0;
    ifb.bpEn = 1; ifb.bpAddr = 32'd3;
    for (int p = 0; p < 4; p++) begin
      feed_b(1'b1, 32'(p));
      if (p == 2) chk("p0_done_early", 128'(ifb.done), 128'd0);
    end
    chk("p0_done", 128'(ifb.done),  128'd1);
    chk("p0_hit",  128'(ifb.hit),   128'd1);
    chk("p0_cnt",  128'(ifb.count), 128'd4);
    ifb.valid = 0; ifb.rdIdx = 4'd3;
    tick();
    chk("p0_rd3", 128'(ifb.rdData), ent(3));

    // Watchdog: valid on odd cycles, no breakpoint
    ifa.bpEn = 0;
    arm_a();
    for (int k = 1; k <= 120; k++) begin
      feed_a(k % 2 == 1, 32'(k));
      if (k == 119) begin
        chk("wd_done_early", 128'(ifa.done),   128'd0);
        chk("wd_cyc119",     128'(ifa.cycles), 128'd119);
      end
    end
    ifa.valid = 0;
    chk("wd_to",    128'(ifa.timeout), 128'd1);
    chk("wd_cyc",   128'(ifa.cycles),  128'd120);
    chk("wd_cnt",   128'(ifa.count),   128'd16);
    chk("wd_hit",   128'(ifa.hit),     128'd0);
    chk("wd_done",  128'(ifa.done),    128'd1);
    ifa.rdIdx = 4'd0;
    tick();
    chk("wd_cyc_hold", 128'(ifa.cycles), 128'd120);
    chk("wd_rd0",      128'(ifa.rdData), ent(89));
    ifa.rdIdx = 4'd15;
    tick();
    chk("wd_rd15", 128'(ifa.rdData), ent(119));

    // Re-arm from DONE
    arm_a();
    chk("ra_to",   128'(ifa.timeout), 128'd0);
    chk("ra_hit",  128'(ifa.hit),     128'd0);
    chk("ra_cnt",  128'(ifa.count),   128'd0);
    chk("ra_cyc",  128'(ifa.cycles),  128'd0);
    chk("ra_busy", 128'(ifa.busy),    128'd1);
    chk("ra_done", 128'(ifa.done),    128'd0);
    feed_a(1'b1, 32'd0);
    chk("ra_cnt1", 128'(ifa.count), 128'd1);
    ifa.valid = 0; ifa.rdIdx = 4'd0;
    tick();
    chk("ra_rd0", 128'(ifa.rdData), ent(0));

    // Reset in the middle of POST
    ifa.bpEn = 1; ifa.bpAddr = 32'd2;
    arm_a();
    for (int p = 0; p < 4; p++) feed_a(1'b1, 32'(p));
    ifa.valid = 0; ifa.rdIdx = 4'd0;
    tick();
    chk("mr_busy", 128'(ifa.busy),   128'd1);
    chk("mr_hit",  128'(ifa.hit),    128'd1);
    chk("mr_rd",   128'(ifa.rdData), ent(0));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy",  128'(ifa.busy),    128'd0);
    chk("rst_done",  128'(ifa.done),    128'd0);
    chk("rst_hit",   128'(ifa.hit),     128'd0);
    chk("rst_to",    128'(ifa.timeout), 128'd0);
    chk("rst_cnt",   128'(ifa.count),   128'd0);
    chk("rst_cyc",   128'(ifa.cycles),  128'd0);
    chk("rst_rd",    128'(ifa.rdData),  128'd0);
    chk("rst_b_done", 128'(ifb.done),   128'd0);
    tick();
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sm_trace_buffer.md
# sm_trace_buffer

Synthesizable execution-trace recorder for the schoolMIPS core, sitting beside `sm_cpu` and sampling the fetch-side PC/instruction pair every clock. It generalises the bench's cycle printer and cycle timeout into hardware:

- parametrised-depth circular trace of recent instructions;
- PC breakpoint with post-trigger capture;
- cycle watchdog;
- registered readout port that a bench, debug UART or board display can read.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: trace depth is 2^DEPTH_LOG2 entries (16).
- `POST`, 4: entries captured after the breakpoint entry, 0..2^DEPTH_LOG2-1.
- `NCYCLE`, 120: watchdog limit in capture cycles, 1..65535.

Ports:
- `clk` input 1: single clock. All state changes on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `arm` input 1: one-cycle pulse; clears the trace and starts capture.
- `valid` input 1: current `pc`/`instr` pair is a real executed instruction.
- `pc` input 32: word PC (same encoding as regData for regAddr 0).
- `instr` input 32: instruction word at `pc`.
- `watch` input 32: watched register value (used only with `SM_TRACE_WATCH_EN`).
- `bpEn` input 1: breakpoint enable.
- `bpAddr` input 32: breakpoint word PC.
- `rdIdx` input DEPTH_LOG2: readout index, 0 = oldest valid entry.
- `rdData` output 64 (96 with `SM_TRACE_WATCH_EN`): {pc, instr} or {pc, instr, watch} of entry `rdIdx`.
- `busy` output 1: state is RUN or POST.
- `done` output 1: state is DONE; intended as a CPU halt request.
- `hit` output 1: breakpoint matched during this run.
- `timeout` output 1: watchdog expired during this run.
- `count` output DEPTH_LOG2+1: valid entries, saturating at 2^DEPTH_LOG2.
- `cycles` output 16: capture cycles elapsed in this run.

## Operation
States and transitions:
- IDLE → RUN on `arm`.
- RUN → POST on breakpoint match (POST>0).
- RUN → DONE on breakpoint match (POST=0) or watchdog expiry.
- POST → DONE when the post counter reaches POST, or on watchdog expiry.
- DONE → RUN on `arm`.

Behaviour in each state:
- `arm` in any state resets `wrPtr`, `count`, `cycles`, `hit`, `timeout` and the post counter, then enters RUN. Memory contents are not cleared.
- RUN/POST: each cycle increments `cycles`.
- RUN/POST with `valid`=1: write the entry at `wrPtr`. `wrPtr` wraps modulo 2^DEPTH_LOG2. `count` increments, saturating at 2^DEPTH_LOG2, so the oldest entry is overwritten when full.
- Breakpoint: in RUN, `valid` && `bpEn` && `pc`==`bpAddr` captures the matching entry, sets `hit` and starts POST counting.
- Post-trigger: POST counts only valid captures after the match. A breakpoint match while already in POST is ignored.
- Watchdog: when `cycles` reaches NCYCLE, enter DONE and set `timeout`. The entry valid in that cycle is still captured. If the last post capture and expiry coincide, both `hit` and `timeout` end up 1.
- IDLE/DONE: no writes. `cycles`, `count` and flags hold.
- Readout address is (`wrPtr` − `count` + `rdIdx`) mod depth. `rdIdx` ≥ `count` returns unspecified data.

## Timing
- Reset (async assert, sync-released by the system) forces: IDLE, `wrPtr`=0, `count`=0, `cycles`=0, `hit`=0, `timeout`=0, `busy`=0, `done`=0, `rdData`=0.
- Reset mid-run aborts immediately to the values above. Trace memory content is unspecified after reset.
- `arm` sampled at edge N: `busy`=1 after N, and the first capture occurs at edge N+1.
- Capture: inputs sampled at edge N are visible in `count` after N and readable at edge N+1.
- Readout: `rdData` is registered. `rdIdx` applied before edge N gives data after edge N (1-cycle latency). Reading is allowed in any state.
- Done timing:
  - `done` rises after the edge that captures the last post entry (breakpoint path);
  - or after the edge where `cycles` becomes NCYCLE (watchdog path).
- Status outputs are registered; none is combinational from inputs.

## Configuration
- `SM_TRACE_WATCH_EN` defined:
  - entries are 96 bits {pc, instr, watch};
  - `rdData` is 96 bits.
- `SM_TRACE_WATCH_EN` undefined:
  - entries and `rdData` are 64 bits;
  - `watch` is unused.
- All other behaviour is identical in both builds.

## Test plan
- Reset/idle: hold `rst_n`=0 4 cycles, then feed `valid`=1 with `pc`=0..9, no `arm` → `count`=0, `busy`=0, `done`=0, `rdData`=0.
- Wrap: DEPTH_LOG2=4, `arm`, 20 valid entries `pc`=0..19, `bpEn`=0 → `count`=16, `cycles`=20. `rdIdx`=0 reads pc 4; `rdIdx`=15 reads pc 19.
- Breakpoint with post: POST=4, `bpAddr`=7, `pc`=0..15 valid every cycle → `hit`=1, `done`=1 after pc 11 is captured, `count`=12, newest entry pc 11.
- Breakpoint with POST=0: `bpAddr`=3 → `done` after pc 3 captured, `count`=4, `rdIdx`=3 reads {3, instr3}.
- Watchdog: NCYCLE=120, `valid` toggling every other cycle, no breakpoint → `timeout`=1, `cycles`=120, `count`=16 (saturated), `hit`=0.
- Re-arm and reset: re-arm in DONE → flags cleared, new run captures from pc 0. Asserting `rst_n`=0 mid-POST → IDLE and all outputs 0 immediately. With `SM_TRACE_WATCH_EN`, `watch`=32'hAA appears in `rdData[31:0]`.
